asic_cmd_ctrl: RTL and testbench

- Command front end of the Asic matrix/vector accelerator. Sits directly downstream of the processor command/response interface (cmd_*, resp_*) and upstream of the compute/memory datapath.
- Decodes custom-instruction commands and latches job configuration: W/X/R base addresses, a, k, M, N, ReLU.
- Validates and launches a job, waits for datapath completion, then returns a status word to rd.
- Status word: 0 = success, non-zero = error code.

---
 rtl/asic_cmd_pkg.sv | 29 ++
 rtl/asic_cfg_regs.sv | 64 ++++++
 rtl/asic_cmd_ctrl.sv | 131 +++++++++++++
 tb/tb_asic_cmd_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/asic_cmd_pkg.sv
// Shared types and constants for the Asic command front end.
package asic_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [6:0] FN_WADDR = 7'd0;
    localparam logic [6:0] FN_XADDR = 7'd1;
    localparam logic [6:0] FN_RADDR = 7'd2;
    localparam logic [6:0] FN_DIMS  = 7'd3;
    localparam logic [6:0] FN_START = 7'd4;

    localparam logic [2:0] ST_OK      = 3'd0;
    localparam logic [2:0] ST_BADFN   = 3'd1;
    localparam logic [2:0] ST_ZERODIM = 3'd2;
    localparam logic [2:0] ST_DPERR   = 3'd3;
    localparam logic [2:0] ST_ALIGN   = 3'd4;

    // Field offsets inside rs1 for the dims command
    localparam int unsigned DIM_A_LSB    = 0;
    localparam int unsigned DIM_K_LSB    = 8;
    localparam int unsigned DIM_M_LSB    = 16;
    localparam int unsigned DIM_N_LSB    = 24;
    localparam int unsigned DIM_RELU_BIT = 32;

endpackage

// File: rtl/asic_cfg_regs.sv
// Job configuration registers plus the launch-time validation check.
module asic_cfg_regs
    import asic_cmd_pkg::*;
#(
    parameter int unsigned ADDR_W = 40,
    parameter int unsigned XLEN   = 64,
    parameter int unsigned DIM_W  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [6:0]        funct,
    input  logic [XLEN-1:0]   rs1,
    output logic [ADDR_W-1:0] cfg_waddr,
    output logic [ADDR_W-1:0] cfg_xaddr,
    output logic [ADDR_W-1:0] cfg_raddr,
    output logic [DIM_W-1:0]  cfg_a,
    output logic [DIM_W-1:0]  cfg_k,
    output logic [DIM_W-1:0]  cfg_m,
    output logic [DIM_W-1:0]  cfg_n,
    output logic              cfg_relu,
    output logic [2:0]        start_status
);

    logic unused_rs1;
    assign unused_rs1 = &{1'b0, rs1};

    always_ff @(posedge clk) begin
        if (!reset) begin
            cfg_waddr <= '0;
            cfg_xaddr <= '0;
            cfg_raddr <= '0;
            cfg_a     <= '0;
            cfg_k     <= '0;
            cfg_m     <= '0;
            cfg_n     <= '0;
            cfg_relu  <= 1'b0;
        end else if (wr_en) begin
            case (funct)
                FN_WADDR: cfg_waddr <= rs1[ADDR_W-1:0];
                FN_XADDR: cfg_xaddr <= rs1[ADDR_W-1:0];
                FN_RADDR: cfg_raddr <= rs1[ADDR_W-1:0];
                FN_DIMS: begin
                    cfg_a    <= rs1[DIM_A_LSB +: DIM_W];
                    cfg_k    <= rs1[DIM_K_LSB +: DIM_W];
                    cfg_m    <= rs1[DIM_M_LSB +: DIM_W];
                    cfg_n    <= rs1[DIM_N_LSB +: DIM_W];
                    cfg_relu <= rs1[DIM_RELU_BIT];
                end
                default: ;
            endcase
        end
    end

    // Zero dimension takes priority over misalignment
    always_comb begin
        start_status = ST_OK;
        if (cfg_m == '0 || cfg_n == '0)
            start_status = ST_ZERODIM;
        else if (cfg_waddr[2:0] != '0 || cfg_xaddr[2:0] != '0 || cfg_raddr[2:0] != '0)
            start_status = ST_ALIGN;
    end

endmodule

// File: rtl/asic_cmd_ctrl.sv
// Command front end: decodes commands, launches jobs and returns status words.
module asic_cmd_ctrl
    import asic_cmd_pkg::*;
#(
    parameter int unsigned ADDR_W = 40,
    parameter int unsigned XLEN   = 64,
    parameter int unsigned DIM_W  = 7
) (
    input  logic              clk,
    input  logic              reset,
    output logic              cmd_ready_o,
    input  logic              cmd_valid_i,
    input  logic [6:0]        cmd_inst_funct_i,
    input  logic [4:0]        cmd_inst_rs2_i,
    input  logic [4:0]        cmd_inst_rs1_i,
    input  logic              cmd_inst_xd_i,
    input  logic              cmd_inst_xs1_i,
    input  logic              cmd_inst_xs2_i,
    input  logic [4:0]        cmd_inst_rd_i,
    input  logic [6:0]        cmd_inst_opcode_i,
    input  logic [XLEN-1:0]   cmd_rs1_i,
    input  logic              resp_ready_i,
    output logic              resp_valid_o,
    output logic [4:0]        resp_rd_o,
    output logic [XLEN-1:0]   resp_data_o,
    output logic [ADDR_W-1:0] cfg_waddr_o,
    output logic [ADDR_W-1:0] cfg_xaddr_o,
    output logic [ADDR_W-1:0] cfg_raddr_o,
    output logic [DIM_W-1:0]  cfg_a_o,
    output logic [DIM_W-1:0]  cfg_k_o,
    output logic [DIM_W-1:0]  cfg_m_o,
    output logic [DIM_W-1:0]  cfg_n_o,
    output logic              cfg_relu_o,
    output logic              start_o,
    output logic              busy_o,
    input  logic              done_i,
    input  logic              done_err_i
);

    state_t     state;
    logic       cmd_fire;
    logic       xd_q;
    logic [2:0] status_q;
    logic [2:0] start_status;
    logic       unused_inst;

    assign unused_inst = &{1'b0, cmd_inst_rs2_i, cmd_inst_rs1_i, cmd_inst_xs1_i,
                           cmd_inst_xs2_i, cmd_inst_opcode_i};

    // Reset gating keeps ready low for the whole time reset is held
    assign cmd_ready_o  = reset && (state == IDLE);
    assign cmd_fire     = cmd_valid_i && cmd_ready_o;
    assign busy_o       = (state == RUN);
    assign resp_valid_o = (state == RESP);
    assign resp_data_o  = {{(XLEN-3){1'b0}}, status_q};

    asic_cfg_regs #(
        .ADDR_W (ADDR_W),
        .XLEN   (XLEN),
        .DIM_W  (DIM_W)
    ) u_cfg_regs (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (cmd_fire),
        .funct        (cmd_inst_funct_i),
        .rs1          (cmd_rs1_i),
        .cfg_waddr    (cfg_waddr_o),
        .cfg_xaddr    (cfg_xaddr_o),
        .cfg_raddr    (cfg_raddr_o),
        .cfg_a        (cfg_a_o),
        .cfg_k        (cfg_k_o),
        .cfg_m        (cfg_m_o),
        .cfg_n        (cfg_n_o),
        .cfg_relu     (cfg_relu_o),
        .start_status (start_status)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            start_o   <= 1'b0;
            xd_q      <= 1'b0;
            status_q  <= '0;
            resp_rd_o <= '0;
        end else begin
            start_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        resp_rd_o <= cmd_inst_rd_i;
                        case (cmd_inst_funct_i)
                            FN_WADDR, FN_XADDR, FN_RADDR, FN_DIMS: begin
                                status_q <= ST_OK;
                                if (cmd_inst_xd_i)
                                    state <= RESP;
                            end
                            FN_START: begin
                                xd_q <= cmd_inst_xd_i;
                                if (start_status == ST_OK) begin
                                    start_o <= 1'b1;
                                    state   <= RUN;
                                end else begin
                                    status_q <= start_status;
                                    if (cmd_inst_xd_i)
                                        state <= RESP;
                                end
                            end
                            default: begin
                                status_q <= ST_BADFN;
                                if (cmd_inst_xd_i)
                                    state <= RESP;
                            end
                        endcase
                    end
                end
                RUN: begin
                    if (done_i) begin
                        status_q <= done_err_i ? ST_DPERR : ST_OK;
                        state    <= xd_q ? RESP : IDLE;
                    end
                end
                RESP: begin
                    if (resp_ready_i)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_asic_cmd_ctrl.sv
// Randomized self-checking bench for asic_cmd_ctrl against a transaction-level model.
module tb_asic_cmd_ctrl;

    localparam int ADDR_W = 40;
    localparam int XLEN   = 64;
    localparam int DIM_W  = 7;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              cmd_ready_o;
    logic              cmd_valid_i = 1'b0;
    logic [6:0]        cmd_inst_funct_i = '0;
    logic [4:0]        cmd_inst_rs2_i = '0;
    logic [4:0]        cmd_inst_rs1_i = '0;
    logic              cmd_inst_xd_i = 1'b0;
    logic              cmd_inst_xs1_i = 1'b0;
    logic              cmd_inst_xs2_i = 1'b0;
    logic [4:0]        cmd_inst_rd_i = '0;
    logic [6:0]        cmd_inst_opcode_i = '0;
    logic [XLEN-1:0]   cmd_rs1_i = '0;
    logic              resp_ready_i = 1'b0;
    logic              resp_valid_o;
    logic [4:0]        resp_rd_o;
    logic [XLEN-1:0]   resp_data_o;
    logic [ADDR_W-1:0] cfg_waddr_o, cfg_xaddr_o, cfg_raddr_o;
    logic [DIM_W-1:0]  cfg_a_o, cfg_k_o, cfg_m_o, cfg_n_o;
    logic              cfg_relu_o;
    logic              start_o;
    logic              busy_o;
    logic              done_i = 1'b0;
    logic              done_err_i = 1'b0;

    asic_cmd_ctrl #(
        .ADDR_W (ADDR_W),
        .XLEN   (XLEN),
        .DIM_W  (DIM_W)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .cmd_ready_o       (cmd_ready_o),
        .cmd_valid_i       (cmd_valid_i),
        .cmd_inst_funct_i  (cmd_inst_funct_i),
        .cmd_inst_rs2_i    (cmd_inst_rs2_i),
        .cmd_inst_rs1_i    (cmd_inst_rs1_i),
        .cmd_inst_xd_i     (cmd_inst_xd_i),
        .cmd_inst_xs1_i    (cmd_inst_xs1_i),
        .cmd_inst_xs2_i    (cmd_inst_xs2_i),
        .cmd_inst_rd_i     (cmd_inst_rd_i),
        .cmd_inst_opcode_i (cmd_inst_opcode_i),
        .cmd_rs1_i         (cmd_rs1_i),
        .resp_ready_i      (resp_ready_i),
        .resp_valid_o      (resp_valid_o),
        .resp_rd_o         (resp_rd_o),
        .resp_data_o       (resp_data_o),
        .cfg_waddr_o       (cfg_waddr_o),
        .cfg_xaddr_o       (cfg_xaddr_o),
        .cfg_raddr_o       (cfg_raddr_o),
        .cfg_a_o           (cfg_a_o),
        .cfg_k_o           (cfg_k_o),
        .cfg_m_o           (cfg_m_o),
        .cfg_n_o           (cfg_n_o),
        .cfg_relu_o        (cfg_relu_o),
        .start_o           (start_o),
        .busy_o            (busy_o),
        .done_i            (done_i),
        .done_err_i        (done_err_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference configuration as the processor believes it was programmed
    logic [63:0] m_w, m_x, m_r;
    logic [63:0] m_a, m_k, m_m, m_n, m_relu;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_w = 0; m_x = 0; m_r = 0;
        m_a = 0; m_k = 0; m_m = 0; m_n = 0; m_relu = 0;
    endtask

    task automatic check_cfg();
        check("cfg_waddr", cfg_waddr_o, m_w);
        check("cfg_xaddr", cfg_xaddr_o, m_x);
        check("cfg_raddr", cfg_raddr_o, m_r);
        check("cfg_a",     cfg_a_o,     m_a);
        check("cfg_k",     cfg_k_o,     m_k);
        check("cfg_m",     cfg_m_o,     m_m);
        check("cfg_n",     cfg_n_o,     m_n);
        check("cfg_relu",  cfg_relu_o,  m_relu);
    endtask

    task automatic check_idle_quiet();
        check("idle_resp_valid", resp_valid_o, 0);
        check("idle_busy",       busy_o,       0);
        check("idle_start",      start_o,      0);
        check("idle_cmd_ready",  cmd_ready_o,  1);
    endtask

    task automatic issue(input logic [6:0] funct, input logic [63:0] rs1,
                         input bit xd, input logic [4:0] rd);
        int n = 0;
        while (!cmd_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready_o) check("cmd_ready_timeout", cmd_ready_o, 1);
        cmd_valid_i       = 1'b1;
        cmd_inst_funct_i  = funct;
        cmd_rs1_i         = rs1;
        cmd_inst_xd_i     = xd;
        cmd_inst_rd_i     = rd;
        cmd_inst_rs2_i    = 5'($urandom);
        cmd_inst_rs1_i    = 5'($urandom);
        cmd_inst_xs1_i    = 1'($urandom);
        cmd_inst_xs2_i    = 1'($urandom);
        cmd_inst_opcode_i = 7'($urandom);
        @(negedge clk);
        cmd_valid_i = 1'b0;
        cmd_rs1_i   = {$urandom, $urandom};
    endtask

    task automatic take_resp(input logic [4:0] rd, input logic [63:0] st, input int bp);
        check("resp_valid", resp_valid_o, 1);
        check("resp_rd",    resp_rd_o,    rd);
        check("resp_data",  resp_data_o,  st);
        check("resp_cmd_ready", cmd_ready_o, 0);
        for (int i = 0; i < bp; i++) begin
            resp_ready_i = 1'b0;
            @(negedge clk);
            check("bp_resp_valid", resp_valid_o, 1);
            check("bp_resp_rd",    resp_rd_o,    rd);
            check("bp_resp_data",  resp_data_o,  st);
            check("bp_cmd_ready",  cmd_ready_o,  0);
        end
        resp_ready_i = 1'b1;
        @(negedge clk);
        resp_ready_i = 1'b0;
        check("post_resp_valid", resp_valid_o, 0);
        check("post_resp_ready", cmd_ready_o,  1);
    endtask

    task automatic run_cmd(input logic [6:0] funct, input logic [63:0] rs1, input bit xd,
                           input logic [4:0] rd, input int dly, input bit err, input int bp);
        logic [63:0] st = 0;
        bit launch = 0;
        if (funct <= 3) begin
            case (funct)
                0: m_w = rs1 & 64'hFF_FFFF_FFFF;
                1: m_x = rs1 & 64'hFF_FFFF_FFFF;
                2: m_r = rs1 & 64'hFF_FFFF_FFFF;
                default: begin
                    m_a    = (rs1 >> 0)  & 64'h7f;
                    m_k    = (rs1 >> 8)  & 64'h7f;
                    m_m    = (rs1 >> 16) & 64'h7f;
                    m_n    = (rs1 >> 24) & 64'h7f;
                    m_relu = (rs1 >> 32) & 64'h1;
                end
            endcase
        end else if (funct == 4) begin
            if (m_m == 0 || m_n == 0) st = 2;
            else if ((m_w % 8) != 0 || (m_x % 8) != 0 || (m_r % 8) != 0) st = 4;
            else launch = 1;
        end else begin
            st = 1;
        end
        issue(funct, rs1, xd, rd);
        if (launch) begin
            check("start_pulse", start_o, 1);
            check("run_busy", busy_o, 1);
            check("run_cmd_ready", cmd_ready_o, 0);
            check_cfg();
            @(negedge clk);
            check("start_pulse_end", start_o, 0);
            for (int i = 0; i < dly; i++) begin
                check("run_wait_busy", busy_o, 1);
                check("run_wait_valid", resp_valid_o, 0);
                @(negedge clk);
            end
            done_i     = 1'b1;
            done_err_i = err;
            @(negedge clk);
            done_i     = 1'b0;
            done_err_i = 1'b0;
            st = err ? 3 : 0;
            check("post_done_busy", busy_o, 0);
            check_cfg();
            if (xd) take_resp(rd, st, bp);
            else check_idle_quiet();
        end else begin
            check("no_start", start_o, 0);
            check_cfg();
            if (xd) take_resp(rd, st, bp);
            else check_idle_quiet();
        end
    endtask

    function automatic logic [63:0] dims(input int a, input int k, input int m,
                                         input int n, input int relu);
        return (64'(a) << 0) | (64'(k) << 8) | (64'(m) << 16) | (64'(n) << 24) | (64'(relu) << 32);
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0]  f;
        logic [63:0] v;
        int          r;

        model_reset();
        repeat (3) @(negedge clk);
        check("rst_cmd_ready",  cmd_ready_o,  0);
        check("rst_resp_valid", resp_valid_o, 0);
        check("rst_start",      start_o,      0);
        check("rst_busy",       busy_o,       0);
        check("rst_resp_rd",    resp_rd_o,    0);
        check("rst_resp_data",  resp_data_o,  0);
        check_cfg();
        reset = 1'b1;
        @(negedge clk);
        check("rst_release_ready", cmd_ready_o, 1);

        // Config then successful start
        run_cmd(0, 64'h0,  0, 0, 0, 0, 0);
        run_cmd(1, 64'h20, 0, 0, 0, 0, 0);
        run_cmd(2, 64'h30, 0, 0, 0, 0, 0);
        run_cmd(3, dims(0, 1, 2, 2, 0), 0, 0, 0, 0, 0);
        run_cmd(4, 64'h0, 1, 5, 3, 0, 0);

        // Zero dimension
        run_cmd(3, dims(0, 1, 2, 0, 0), 0, 0, 0, 0, 0);
        run_cmd(4, 64'h0, 1, 6, 0, 0, 0);

        // Misaligned Raddr, config itself answered
        run_cmd(3, dims(3, 1, 2, 2, 1), 1, 2, 0, 0, 0);
        run_cmd(2, 64'h31, 1, 3, 0, 0, 1);
        run_cmd(4, 64'h0, 1, 7, 0, 0, 0);

        // Backpressure on a successful job
        run_cmd(2, 64'h30, 0, 0, 0, 0, 0);
        run_cmd(4, 64'h0, 1, 9, 2, 0, 10);

        // Bad funct, datapath error, silent start
        run_cmd(9, 64'hFFFF_FFFF_FFFF_FFFF, 1, 11, 0, 0, 0);
        run_cmd(127, 64'h1234_5678, 0, 12, 0, 0, 0);
        run_cmd(4, 64'h0, 1, 13, 4, 1, 2);
        run_cmd(4, 64'h0, 0, 14, 1, 0, 0);

        // Reset in the middle of a job
        issue(4, 64'h0, 1, 15);
        check("mid_start", start_o, 1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_ready_low", cmd_ready_o, 0);
        reset = 1'b1;
        model_reset();
        done_i = 1'b1;
        @(negedge clk);
        done_i = 1'b0;
        check("mid_rst_resp_rd",   resp_rd_o,   0);
        check("mid_rst_resp_data", resp_data_o, 0);
        check_cfg();
        check_idle_quiet();
        repeat (2) @(negedge clk);
        check_idle_quiet();

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 15);
            if (r < 4)       f = 7'(r);
            else if (r < 10) f = 7'd4;
            else             f = 7'($urandom_range(5, 127));
            v = {$urandom, $urandom};
            if (f <= 2 && $urandom_range(0, 3) != 0) v = v & ~64'h7;
            if (f == 3 && $urandom_range(0, 4) == 0) v = v & ~(64'h7f << 16);
            if (f == 3 && $urandom_range(0, 4) == 0) v = v & ~(64'h7f << 24);
            run_cmd(f, v, 1'($urandom), 5'($urandom), $urandom_range(0, 6),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                done_i     = 1'b1;
                done_err_i = 1'($urandom);
                @(negedge clk);
                done_i     = 1'b0;
                done_err_i = 1'b0;
                check_idle_quiet();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
